fifo_drain_checker: RTL and testbench

FIFO_DRAIN_CHECKER -- requirements
Module: fifo_drain_checker

---
 rtl/fifo_drain_checker.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_drain_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_checker.sv
// Purpose: drains four output FIFOs (4..7) one pop per cycle and checks each word's route tag.
// Latency: pop is registered; the popped word is checked one cycle later; a counter read answers one cycle after req.
// Backpressure: pops are issued only while enable=1; a FIFO that is empty, or was popped in the current cycle, is never selected.
//
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   enable                : 1 = drain the FIFOs, 0 = stop issuing pops
//   FIFO_data_out4..7     : FIFO read data, valid the cycle after the matching pop
//   empty4..7             : FIFO empty flags
//   almost_full4..7       : FIFO almost-full flags (served first, lowest index wins)
//   pop4..7               : registered pop strobes, at most one high per cycle
//   req, idx              : counter read request and counter select (0..3 -> FIFO 4..7)
//   IDLE                  : high while the block is in its IDLE state
//   valid_contador        : counter read data valid
//   contador_out          : selected per-FIFO word count (mod 32)
//   error, err_count      : sticky mis-route flag and saturating mis-route count
module fifo_drain_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] FIFO_data_out4,
  input  logic [9:0] FIFO_data_out5,
  input  logic [9:0] FIFO_data_out6,
  input  logic [9:0] FIFO_data_out7,
  input  logic       empty4,
  input  logic       empty5,
  input  logic       empty6,
  input  logic       empty7,
  input  logic       almost_full4,
  input  logic       almost_full5,
  input  logic       almost_full6,
  input  logic       almost_full7,
  output logic       pop4,
  output logic       pop5,
  output logic       pop6,
  output logic       pop7,
  input  logic       req,
  input  logic [1:0] idx,
  output logic       IDLE,
  output logic       valid_contador,
  output logic [4:0] contador_out,
  output logic       error,
  output logic [4:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_pop;
  logic [1:0]      r_pop_idx;
  logic [1:0]      r_rr_ptr;      // next index the round-robin search starts from
  logic            r_chk_vld;
  logic [1:0]      r_chk_idx;
  logic [3:0][4:0] r_cnt;
  logic            r_error;
  logic [4:0]      r_err_count;
  logic            r_valid;
  logic [4:0]      r_cnt_out;

  logic [3:0]      w_empty;
  logic [3:0]      w_af;
  logic [3:0]      w_cand;
  logic [3:0]      w_af_cand;
  logic            w_any_data;
  logic            w_sel_vld;
  logic [1:0]      w_sel_idx;
  logic [1:0]      w_rr_k;
  logic [9:0]      w_rd_data;
  logic            w_tag_ok;
  logic            w_unused_payload;

  assign w_empty    = {empty7, empty6, empty5, empty4};
  assign w_af       = {almost_full7, almost_full6, almost_full5, almost_full4};
  assign w_any_data = ~&w_empty;

  // The FIFO being popped this cycle still shows its pre-pop empty flag, so it
  // is excluded from the next selection; otherwise its last word could be
  // popped twice.
  assign w_cand    = ~w_empty & ~r_pop;
  assign w_af_cand = w_cand & w_af;

  // Almost-full FIFOs win (lowest index first); otherwise round-robin from r_rr_ptr.
  // Loops run downward so the preferred candidate is the last one assigned.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = 2'd0;
    w_rr_k    = 2'd0;
    if (|w_af_cand) begin
      w_sel_vld = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (w_af_cand[i]) w_sel_idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        w_rr_k = r_rr_ptr + 2'(i);
        if (w_cand[w_rr_k]) begin
          w_sel_vld = 1'b1;
          w_sel_idx = w_rr_k;
        end
      end
    end
  end

  // Control FSM; pops are registered so they are only ever high in DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pop     <= 4'b0000;
      r_pop_idx <= 2'd0;
      r_rr_ptr  <= 2'd0;
    end else begin
      r_pop <= 4'b0000;
      case (r_state)
        ST_IDLE: begin
          if (enable && w_any_data) begin
            r_state <= ST_DRAIN;
            if (w_sel_vld) begin
              r_pop     <= 4'b0001 << w_sel_idx;
              r_pop_idx <= w_sel_idx;
              r_rr_ptr  <= w_sel_idx + 2'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (!enable || !w_any_data) begin
            r_state <= ST_FLUSH;
          end else if (w_sel_vld) begin
            r_pop     <= 4'b0001 << w_sel_idx;
            r_pop_idx <= w_sel_idx;
            r_rr_ptr  <= w_sel_idx + 2'd1;
          end
        end
        default: begin
          // FLUSH: the word from the last DRAIN pop is checked at this edge.
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_data = FIFO_data_out4;
    case (r_chk_idx)
      2'd0:    w_rd_data = FIFO_data_out4;
      2'd1:    w_rd_data = FIFO_data_out5;
      2'd2:    w_rd_data = FIFO_data_out6;
      default: w_rd_data = FIFO_data_out7;
    endcase
  end

  // Bits [9:8] carry the destination tag; the payload is not inspected.
  assign w_tag_ok         = (w_rd_data[9:8] == r_chk_idx);
  assign w_unused_payload = ^w_rd_data[7:0];

  // Word check, counters and the counter read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chk_vld   <= 1'b0;
      r_chk_idx   <= 2'd0;
      r_cnt       <= '0;
      r_error     <= 1'b0;
      r_err_count <= 5'd0;
      r_valid     <= 1'b0;
      r_cnt_out   <= 5'd0;
    end else begin
      r_chk_vld <= |r_pop;
      r_chk_idx <= r_pop_idx;

      if (r_chk_vld) begin
        // Mis-routed words still count against the FIFO they came from.
        r_cnt[r_chk_idx] <= r_cnt[r_chk_idx] + 5'd1;
        if (!w_tag_ok) begin
          r_error <= 1'b1;
          if (r_err_count != 5'd31) r_err_count <= r_err_count + 5'd1;
        end
      end

      if (r_state == ST_IDLE && req) begin
        r_valid   <= 1'b1;
        r_cnt_out <= r_cnt[idx];
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign pop4           = r_pop[0];
  assign pop5           = r_pop[1];
  assign pop6           = r_pop[2];
  assign pop7           = r_pop[3];
  assign IDLE           = (r_state == ST_IDLE);
  assign valid_contador = r_valid;
  assign contador_out   = r_cnt_out;
  assign error          = r_error;
  assign err_count      = r_err_count;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Purpose: directed bench for fifo_drain_checker with a behavioural model of the four output FIFOs.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Backpressure: the FIFO model pops exactly when the DUT's registered pop is high at an edge.
module tb_fifo_drain_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       req;
  logic [1:0] idx;
  logic [9:0] fdo [4];
  logic [3:0] emp;
  logic [3:0] af;
  logic       pop4, pop5, pop6, pop7;
  logic       idle_o;
  logic       valid_c;
  logic [4:0] cnt_o;
  logic       err_o;
  logic [4:0] errc_o;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  logic [9:0] q3[$];
  int         pop_cnt [4];
  int         pop_log[$];
  int         n_checks;
  int         n_errors;

  fifo_drain_checker dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .FIFO_data_out4 (fdo[0]),
    .FIFO_data_out5 (fdo[1]),
    .FIFO_data_out6 (fdo[2]),
    .FIFO_data_out7 (fdo[3]),
    .empty4         (emp[0]),
    .empty5         (emp[1]),
    .empty6         (emp[2]),
    .empty7         (emp[3]),
    .almost_full4   (af[0]),
    .almost_full5   (af[1]),
    .almost_full6   (af[2]),
    .almost_full7   (af[3]),
    .pop4           (pop4),
    .pop5           (pop5),
    .pop6           (pop6),
    .pop7           (pop7),
    .req            (req),
    .idx            (idx),
    .IDLE           (idle_o),
    .valid_contador (valid_c),
    .contador_out   (cnt_o),
    .error          (err_o),
    .err_count      (errc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    emp[0] = (q0.size() == 0);
    emp[1] = (q1.size() == 0);
    emp[2] = (q2.size() == 0);
    emp[3] = (q3.size() == 0);
  endtask

  task automatic push(input int n, input logic [9:0] w);
    case (n)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      2:       q2.push_back(w);
      default: q3.push_back(w);
    endcase
    refresh();
  endtask

  task automatic popq(input int n);
    case (n)
      0:       if (q0.size() > 0) fdo[0] = q0.pop_front();
      1:       if (q1.size() > 0) fdo[1] = q1.pop_front();
      2:       if (q2.size() > 0) fdo[2] = q2.pop_front();
      default: if (q3.size() > 0) fdo[3] = q3.pop_front();
    endcase
  endtask

  // One clock: sample pops mid-cycle, then apply them to the FIFO model just after the edge.
  task automatic tick();
    logic [3:0] p;
    @(negedge clk);
    p = {pop7, pop6, pop5, pop4};
    if (p != 4'b0000) chk("pop_legal", ((p & emp) == 4'b0000) && ($countones(p) == 1), 1);
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (p[n]) begin
        pop_cnt[n]++;
        pop_log.push_back(n);
        popq(n);
      end
    end
    refresh();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(idle_o === 1'b1 && emp === 4'hF) && n < 1000);
    chk({tag, "_drained"}, (idle_o === 1'b1 && emp === 4'hF), 1);
  endtask

  task automatic rd(input string tag, input logic [1:0] k, input int exp);
    req = 1'b1;
    idx = k;
    tick();
    chk({tag, "_valid"}, valid_c, 1);
    chk({tag, "_count"}, cnt_o, exp);
    req = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, valid_c, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_pops"}, {pop7, pop6, pop5, pop4}, 0);
    chk({tag, "_idle"}, idle_o, 1);
    chk({tag, "_valid"}, valid_c, 0);
    chk({tag, "_cnt_out"}, cnt_o, 0);
    chk({tag, "_error"}, err_o, 0);
    chk({tag, "_err_count"}, errc_o, 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = 1'b0;
    af     = 4'b0000;
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    refresh();
    pop_log.delete();
    for (int n = 0; n < 4; n++) pop_cnt[n] = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    req      = 1'b0;
    idx      = 2'd0;
    af       = 4'b0000;
    emp      = 4'hF;
    for (int n = 0; n < 4; n++) begin
      fdo[n]     = 10'd0;
      pop_cnt[n] = 0;
    end

    // Reset state
    tick();
    tick();
    check_reset_outs("rst");
    reset = 1'b0;
    tick();
    chk("rst_stay_idle", idle_o, 1);
    rd("rst_cnt2", 2'd2, 0);

    // Scenario 1: 6 correctly tagged words per FIFO
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 6; k++) push(n, {n[1:0], 8'(k)});
    enable = 1'b1;
    wait_idle("s1");
    enable = 1'b0;
    chk("s1_total_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 24);
    chk("s1_error", err_o, 0);
    chk("s1_err_count", errc_o, 0);
    rd("s1_cnt0", 2'd0, 6);
    rd("s1_cnt1", 2'd1, 6);
    rd("s1_cnt2", 2'd2, 6);
    rd("s1_cnt3", 2'd3, 6);

    // Scenario 2: almost_full6 served first, then round-robin resumes after 6
    do_reset();
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++) push(n, {n[1:0], 8'(k)});
    af     = 4'b0100;
    enable = 1'b1;
    tick();
    chk("s2_first_pop", {pop7, pop6, pop5, pop4}, 4'b0100);
    af = 4'b0000;
    wait_idle("s2");
    enable = 1'b0;
    chk("s2_npops", pop_log.size(), 8);
    chk("s2_seq0", pop_log[0], 2);
    chk("s2_seq1", pop_log[1], 3);
    chk("s2_seq2", pop_log[2], 0);
    chk("s2_seq3", pop_log[3], 1);
    rd("s2_cnt2", 2'd2, 2);

    // Scenario 3: one mis-routed word on FIFO5
    do_reset();
    push(1, {2'b11, 8'h5A});
    enable = 1'b1;
    wait_idle("s3");
    enable = 1'b0;
    chk("s3_error", err_o, 1);
    chk("s3_err_count", errc_o, 1);
    rd("s3_cnt1", 2'd1, 1);
    rd("s3_cnt0", 2'd0, 0);

    // Scenario 4: 33 words on FIFO4 wrap the counter; req during DRAIN is ignored
    do_reset();
    for (int k = 0; k < 33; k++) push(0, {2'b00, 8'(k)});
    enable = 1'b1;
    tick();
    chk("s4_left_idle", idle_o, 0);
    req = 1'b1;
    idx = 2'd0;
    tick();
    chk("s4_req_ignored_valid", valid_c, 0);
    chk("s4_req_ignored_out", cnt_o, 0);
    req = 1'b0;
    wait_idle("s4");
    enable = 1'b0;
    chk("s4_pops", pop_cnt[0], 33);
    chk("s4_error", err_o, 0);
    rd("s4_cnt0_wrap", 2'd0, 1);

    // Scenario 5: enable drops while the third pop of FIFO7 is out
    do_reset();
    for (int k = 0; k < 6; k++) push(3, {2'b11, 8'(k)});
    enable = 1'b1;
    for (int t = 0; t < 50 && !(pop7 === 1'b1 && pop_cnt[3] == 2); t++) tick();
    chk("s5_third_pop", pop7, 1);
    enable = 1'b0;
    tick();
    chk("s5_flush_not_idle", idle_o, 0);
    chk("s5_flush_no_pop", {pop7, pop6, pop5, pop4}, 0);
    tick();
    chk("s5_back_idle", idle_o, 1);
    chk("s5_pops", pop_cnt[3], 3);
    chk("s5_error", err_o, 0);
    rd("s5_cnt3", 2'd3, 3);

    // Scenario 6: reset during DRAIN with a word in flight
    do_reset();
    for (int k = 0; k < 6; k++) push(0, {2'b00, 8'(k)});
    enable = 1'b1;
    tick();
    tick();
    chk("s6_inflight_pop", pop_cnt[0], 1);
    reset = 1'b1;
    #1;
    check_reset_outs("s6_async");
    enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("s6_no_pop", {pop7, pop6, pop5, pop4}, 0);
      chk("s6_idle", idle_o, 1);
    end
    rd("s6_cnt0_cleared", 2'd0, 0);
    enable = 1'b1;
    wait_idle("s6");
    enable = 1'b0;
    chk("s6_pops", pop_cnt[0], 6);
    rd("s6_cnt0_after", 2'd0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
